// File: rtl/multi_ctl_pkg.sv
// rtl/multi_ctl_pkg.sv - shared state encodings, opcodes and control word for multi_ctl
package multi_ctl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       pcwritecond_ne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctl_t;

endpackage

// File: rtl/multi_ctl_dec.sv
// rtl/multi_ctl_dec.sv - Moore output decoder, purely combinational from the current state
module multi_ctl_dec
    import multi_ctl_pkg::*;
(
    input  state_e state_i,
    output ctl_t   ctl_o
);

    always_comb begin
        ctl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctl_o.memread = 1'b1;
                ctl_o.alusrcb = SRCB_FOUR;
                ctl_o.irwrite = 1'b1;
                ctl_o.pcwrite = 1'b1;
            end
            S_DECODE: ctl_o.alusrcb = SRCB_SHIMM;
            S_MEMADR: begin
                ctl_o.alusrca = 1'b1;
                ctl_o.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctl_o.memread = 1'b1;
                ctl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctl_o.regwrite = 1'b1;
                ctl_o.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctl_o.memwrite = 1'b1;
                ctl_o.iord     = 1'b1;
            end
            S_EXEC: begin
                ctl_o.alusrca = 1'b1;
                ctl_o.aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctl_o.regwrite = 1'b1;
                ctl_o.regdst   = 1'b1;
            end
            S_BEQ: begin
                ctl_o.alusrca     = 1'b1;
                ctl_o.aluop       = ALUOP_SUB;
                ctl_o.pcsource    = PCSRC_ALUOUT;
                ctl_o.pcwritecond = 1'b1;
            end
            S_BNE: begin
                ctl_o.alusrca        = 1'b1;
                ctl_o.aluop          = ALUOP_SUB;
                ctl_o.pcsource       = PCSRC_ALUOUT;
                ctl_o.pcwritecond_ne = 1'b1;
            end
            S_JUMP: begin
                ctl_o.pcwrite  = 1'b1;
                ctl_o.pcsource = PCSRC_JUMP;
            end
            S_IEXEC: begin
                ctl_o.alusrca = 1'b1;
                ctl_o.alusrcb = SRCB_IMM;
            end
            S_IWB: ctl_o.regwrite = 1'b1;
            default: ctl_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_ctl.sv
// rtl/multi_ctl.sv - multicycle CPU control FSM: state register, next-state logic and strobe gating
module multi_ctl
    import multi_ctl_pkg::*;
#(
    parameter int MEM_HS = 0,
    parameter int FWIDTH = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FWIDTH-1:0] opcode,
    input  logic              mem_ready,
    output logic              pcwrite,
    output logic              pcwritecond,
    output logic              pcwritecond_ne,
    output logic              iord,
    output logic              memread,
    output logic              memwrite,
    output logic              irwrite,
    output logic              memtoreg,
    output logic              regdst,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        aluop,
    output logic [1:0]        pcsource,
    output logic              illegal,
    output logic [3:0]        state
);

    localparam logic [FWIDTH-1:0] W_R    = FWIDTH'(OP_R);
    localparam logic [FWIDTH-1:0] W_J    = FWIDTH'(OP_J);
    localparam logic [FWIDTH-1:0] W_BEQ  = FWIDTH'(OP_BEQ);
    localparam logic [FWIDTH-1:0] W_BNE  = FWIDTH'(OP_BNE);
    localparam logic [FWIDTH-1:0] W_ADDI = FWIDTH'(OP_ADDI);
    localparam logic [FWIDTH-1:0] W_LW   = FWIDTH'(OP_LW);
    localparam logic [FWIDTH-1:0] W_SW   = FWIDTH'(OP_SW);

    state_e state_q, state_d;
    ctl_t   ctl;
    logic   mem_done;
    logic   op_known;

    assign mem_done = (MEM_HS == 0) || mem_ready;
    assign op_known = (opcode == W_R)    || (opcode == W_J)  || (opcode == W_BEQ) ||
                      (opcode == W_BNE)  || (opcode == W_ADDI) ||
                      (opcode == W_LW)   || (opcode == W_SW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == W_LW || opcode == W_SW) state_d = S_MEMADR;
                else if (opcode == W_R)               state_d = S_EXEC;
                else if (opcode == W_BEQ)             state_d = S_BEQ;
                else if (opcode == W_BNE)             state_d = S_BNE;
                else if (opcode == W_J)               state_d = S_JUMP;
                else if (opcode == W_ADDI)            state_d = S_IEXEC;
                else                                  state_d = S_FETCH;
            end
            S_MEMADR: state_d = (opcode == W_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_done ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_done ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_BNE:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    multi_ctl_dec u_dec (
        .state_i (state_q),
        .ctl_o   (ctl)
    );

    // Reset forces FETCH, whose decoded strobes are active, so strobes are masked while reset is high.
    always_comb begin
        pcwrite        = ctl.pcwrite & ~reset & ((state_q != S_FETCH) | mem_done);
        irwrite        = ctl.irwrite & ~reset & mem_done;
        pcwritecond    = ctl.pcwritecond & ~reset;
        pcwritecond_ne = ctl.pcwritecond_ne & ~reset;
        memread        = ctl.memread & ~reset;
        memwrite       = ctl.memwrite & ~reset;
        regwrite       = ctl.regwrite & ~reset;
        iord           = ctl.iord;
        memtoreg       = ctl.memtoreg;
        regdst         = ctl.regdst;
        alusrca        = ctl.alusrca;
        alusrcb        = ctl.alusrcb;
        aluop          = ctl.aluop;
        pcsource       = ctl.pcsource;
        illegal        = (state_q == S_DECODE) & ~op_known & ~reset;
        state          = state_q;
    end

endmodule
